button_debouncer: RTL and testbench

Cleans a raw, asynchronous push-button input into a glitch-free level `L`. It sits directly upstream of the level-to-pulse converter, which turns each debounced press into a one-cycle pulse. The block synchronises the input with two flops. A four-state FSM plus a stability counter then accepts a change only after the new value has held for `STABLE_CNT` consecutive cycles.

---
 rtl/debounce_pkg.sv | 15 +
 rtl/sync_2ff.sv | 21 ++
 rtl/button_debouncer.sv | 75 +++++++
 tb/tb_button_debouncer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button debouncer.
// State encoding keeps bit 1 equal to the debounced level in the IDLE states.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'b00,
        WAIT_HIGH = 2'b01,
        IDLE_HIGH = 2'b11,
        WAIT_LOW  = 2'b10
    } state_t;

    localparam int DEFAULT_STABLE_CNT = 1000000;
    localparam int DEFAULT_CNT_W      = 20;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, synchronous reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button: a change of the synchronised input is accepted
// only after it has held for STABLE_CNT consecutive cycles.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CNT = DEFAULT_STABLE_CNT,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic L,
    output logic busy
);

    if (STABLE_CNT < 1) begin : g_bad_stable_cnt
        $error("button_debouncer: STABLE_CNT must be >= 1");
    end
    if (longint'(STABLE_CNT) > (longint'(1) << CNT_W)) begin : g_bad_cnt_w
        $error("button_debouncer: CNT_W too narrow for STABLE_CNT");
    end

    localparam logic [CNT_W-1:0] TERM = CNT_W'(STABLE_CNT - 1);

    logic             s;
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Counter is cleared on every transition and in IDLE; it only runs in WAIT
    // and is compared before incrementing, so it never exceeds STABLE_CNT-1.
    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        case (state)
            IDLE_LOW: begin
                if (s) state_nx = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (!s)              state_nx = IDLE_LOW;
                else if (cnt == TERM) state_nx = IDLE_HIGH;
                else                 cnt_nx   = cnt + 1'b1;
            end
            IDLE_HIGH: begin
                if (!s) state_nx = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (s)               state_nx = IDLE_HIGH;
                else if (cnt == TERM) state_nx = IDLE_LOW;
                else                 cnt_nx   = cnt + 1'b1;
            end
            default: state_nx = IDLE_LOW;
        endcase
    end

    assign L    = (state == IDLE_HIGH) || (state == WAIT_LOW);
    assign busy = (state == WAIT_HIGH) || (state == WAIT_LOW);

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: two instances (STABLE_CNT=4 and 1) checked each
// cycle against a run-length model, plus directed latency/bounce/reset cases.
module tb_button_debouncer;
    import debounce_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b0;
    logic L4, busy4, L1, busy1;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    button_debouncer #(.STABLE_CNT(4), .CNT_W(3)) dut4 (
        .clk (clk), .rst (rst), .btn (btn), .L (L4), .busy (busy4)
    );

    button_debouncer #(.STABLE_CNT(1), .CNT_W(1)) dut1 (
        .clk (clk), .rst (rst), .btn (btn), .L (L1), .busy (busy1)
    );

    // Model: the level flips once the synchronised input has disagreed with it
    // for STABLE_CNT+1 consecutive samples; busy while such a run is open.
    int nst [2] = '{4, 1};
    int run [2] = '{0, 0};
    bit ml  [2] = '{1'b0, 1'b0};
    bit ms1 = 1'b0, ms = 1'b0;

    always @(posedge clk) begin
        bit samp;
        if (rst) begin
            ms1 = 1'b0;
            ms  = 1'b0;
            for (int i = 0; i < 2; i++) begin
                ml[i]  = 1'b0;
                run[i] = 0;
            end
        end else begin
            samp = ms;
            ms   = ms1;
            ms1  = btn;
            for (int i = 0; i < 2; i++) begin
                if (samp != ml[i]) begin
                    run[i]++;
                    if (run[i] == nst[i] + 1) begin
                        ml[i]  = ~ml[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("L4",    L4,            ml[0]);
            chk("busy4", busy4,         run[0] > 0);
            chk("cnt4",  int'(dut4.cnt), run[0] > 0 ? run[0] - 1 : 0);
            chk("L1",    L1,            ml[1]);
            chk("busy1", busy1,         run[1] > 0);
            chk("cnt1",  int'(dut1.cnt), run[1] > 0 ? run[1] - 1 : 0);
        end
    end

    task automatic cyc(input bit b, input bit r);
        btn = b;
        rst = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int e4, e1, bc, maxc, seen_l, seen_b, seen_low;
        bit pat [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        @(negedge clk);

        // Reset with button held high.
        cyc(1'b1, 1'b1);
        chk_en = 1'b1;
        cyc(1'b1, 1'b1);
        chk("rst_L4", L4, 0);
        chk("rst_busy4", busy4, 0);
        chk("rst_state4", int'(dut4.state), int'(IDLE_LOW));

        // Fresh press after reset release: full latency.
        e4 = 0; e1 = 0; bc = 0; maxc = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b1, 1'b0);
            if (L4 && e4 == 0) e4 = k;
            if (L1 && e1 == 0) e1 = k;
            if (busy4) bc++;
            if (int'(dut4.cnt) > maxc) maxc = int'(dut4.cnt);
        end
        chk("press_edge4", e4, 7);
        chk("press_edge1", e1, 4);
        chk("press_busy_cycles4", bc, 4);
        chk("cnt_max4", maxc, 3);
        chk("press_hold_L4", L4, 1);

        // Release: same latency.
        e4 = 0; e1 = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b0, 1'b0);
            if (!L4 && e4 == 0) e4 = k;
            if (!L1 && e1 == 0) e1 = k;
        end
        chk("release_edge4", e4, 7);
        chk("release_edge1", e1, 4);

        // Bounce shorter than the qualification window.
        seen_l = 0; seen_b = 0;
        for (int k = 0; k < 18; k++) begin
            cyc(k < 6 ? pat[k] : 1'b0, 1'b0);
            if (L4) seen_l = 1;
            if (busy4) seen_b = 1;
        end
        chk("bounce_L4_seen", seen_l, 0);
        chk("bounce_busy4_seen", seen_b, 1);
        chk("bounce_state4", int'(dut4.state), int'(IDLE_LOW));

        // Two-cycle low glitch while pressed.
        for (int k = 0; k < 12; k++) cyc(1'b1, 1'b0);
        chk("glitch_pre_L4", L4, 1);
        seen_low = 0;
        for (int k = 0; k < 14; k++) begin
            cyc(k < 2 ? 1'b0 : 1'b1, 1'b0);
            if (!L4) seen_low = 1;
        end
        chk("glitch_low_seen4", seen_low, 0);
        for (int k = 0; k < 15; k++) cyc(1'b0, 1'b0);
        chk("idle_again_L4", L4, 0);

        // Reset in WAIT_HIGH with cnt=2.
        for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0);
        chk("midwait_cnt4", int'(dut4.cnt), 2);
        chk("midwait_state4", int'(dut4.state), int'(WAIT_HIGH));
        cyc(1'b1, 1'b1);
        chk("midrst_state4", int'(dut4.state), int'(IDLE_LOW));
        chk("midrst_cnt4", int'(dut4.cnt), 0);
        chk("midrst_busy4", busy4, 0);
        seen_l = 0;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 1'b0);
            if (L4) seen_l = 1;
        end
        chk("midrst_L4_pulse", seen_l, 0);

        // Randomised hold lengths with occasional resets.
        for (int k = 0; k < 300; k++) begin
            bit v;
            int len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++)
                cyc(v, ($urandom_range(0, 149) == 0));
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
